// File: rtl/exec_div_iter_pkg.sv
// -----------------------------------------------------------------------------
// exec_pkg -- shared types and sizing helpers for the iterative divider.
//
// Contents:
//   div_state_t    : divider FSM states (IDLE, RUN, DONE)
//   div_cnt_w()    : iteration-counter width for a given operand width
//   DIV_CNT_W      : counter width for the default 64-bit datapath
// -----------------------------------------------------------------------------
package exec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_XLEN_DEFAULT = 64;

    // The counter must hold XLEN itself (loaded at start), hence XLEN+1.
    function automatic int div_cnt_w(input int xlen);
        return $clog2(xlen + 1);
    endfunction

    localparam int DIV_CNT_W = div_cnt_w(DIV_XLEN_DEFAULT);

endpackage

// File: rtl/exec_div_iter_if.sv
// -----------------------------------------------------------------------------
// exec_div_iter_if -- divide handshake between the integer unit and the
// iterative divider.
//
//   a_in, b_in    : unsigned dividend / divisor, sampled with input_valid
//   do_rem        : 0 = return quotient, 1 = return quotient * divisor
//   input_valid   : one-cycle start strobe
//   q_out         : registered result
//   output_valid  : one-cycle result strobe
//   busy          : divider is iterating
//
// master = integer unit (issues), slave = divider.
// -----------------------------------------------------------------------------
interface exec_div_iter_if #(
    parameter int XLEN = 64
) ();
    logic [XLEN-1:0] a_in;
    logic [XLEN-1:0] b_in;
    logic            do_rem;
    logic            input_valid;
    logic [XLEN-1:0] q_out;
    logic            output_valid;
    logic            busy;

    modport master (
        output a_in, b_in, do_rem, input_valid,
        input  q_out, output_valid, busy
    );

    modport slave (
        input  a_in, b_in, do_rem, input_valid,
        output q_out, output_valid, busy
    );
endinterface

// File: rtl/exec_div_iter_clz.sv
// -----------------------------------------------------------------------------
// div_clz -- combinational leading-zero counter used by the early-out load.
//
//   a_in   : XLEN-bit value
//   lz_out : number of leading zeros; XLEN when a_in is zero
//
// Only instantiated when DIV_EARLY_OUT_EN is defined.
// -----------------------------------------------------------------------------
module div_clz #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic [XLEN-1:0]  a_in,
    output logic [CNT_W-1:0] lz_out
);
    // Scan from LSB upward so the highest set bit wins.
    always_comb begin
        lz_out = CNT_W'(XLEN);
        for (int i = 0; i < XLEN; i++) begin
            if (a_in[i]) begin
                lz_out = CNT_W'(XLEN - 1 - i);
            end
        end
    end
endmodule

// File: rtl/exec_div_iter.sv
// -----------------------------------------------------------------------------
// exec_div_iter -- iterative radix-2 restoring unsigned divider.
//
// Ports:
//   clk     : clock, all state on rising edge
//   rst_n   : asynchronous active-low reset
//   div_if  : exec_div_iter_if.slave (a_in, b_in, do_rem, input_valid,
//             q_out, output_valid, busy)
//
// One quotient bit per cycle. The result is either the quotient or
// (a - remainder) = quotient * divisor; the caller derives the remainder as
// a - q_out. Signs, divide-by-zero and overflow are handled by the caller.
//
// Build option: DIV_EARLY_OUT_EN -- skip the dividend's leading zeros so the
// iteration count becomes max(1, XLEN - clz(a)).
// -----------------------------------------------------------------------------
import exec_pkg::*;

module exec_div_iter #(
    parameter int XLEN = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    exec_div_iter_if.slave div_if
);
    localparam int CNT_W = div_cnt_w(XLEN);

    div_state_t       state_q, state_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  div_q, div_d;
    logic [XLEN-1:0]  a_buf_q, a_buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  q_out_q, q_out_d;
    logic             output_valid_q, output_valid_d;
    logic             busy_q, busy_d;

    logic [XLEN:0]    step_diff;
    logic [XLEN-1:0]  rem_step;
    logic [XLEN-1:0]  quo_step;
    logic [XLEN-1:0]  load_quo;
    logic [CNT_W-1:0] load_cnt;

`ifdef DIV_EARLY_OUT_EN
    logic [CNT_W-1:0] lz;

    div_clz #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_clz (
        .a_in   (div_if.a_in),
        .lz_out (lz)
    );

    // Leading zeros of the dividend only ever produce 0 quotient bits and
    // leave the partial remainder at 0, so they are shifted out up front.
    assign load_quo = div_if.a_in << lz;
    assign load_cnt = (lz == CNT_W'(XLEN)) ? CNT_W'(1) : (CNT_W'(XLEN) - lz);
`else
    assign load_quo = div_if.a_in;
    assign load_cnt = CNT_W'(XLEN);
`endif

    // Trial subtraction; the borrow bit decides restore vs. keep.
    always_comb begin
        step_diff = {rem_q, quo_q[XLEN-1]} - {1'b0, div_q};
        if (!step_diff[XLEN]) begin
            rem_step = step_diff[XLEN-1:0];
            quo_step = {quo_q[XLEN-2:0], 1'b1};
        end else begin
            rem_step = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
            quo_step = {quo_q[XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        quo_d          = quo_q;
        div_d          = div_q;
        a_buf_d        = a_buf_q;
        cnt_d          = cnt_q;
        q_out_d        = q_out_q;
        output_valid_d = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (div_if.input_valid) begin
                    state_d = RUN;
                    rem_d   = '0;
                    quo_d   = load_quo;
                    div_d   = div_if.b_in;
                    a_buf_d = div_if.a_in;
                    cnt_d   = load_cnt;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Result comes from this final step's values, not the
                    // registered ones, so it is ready on the DONE-entry edge.
                    state_d        = DONE;
                    output_valid_d = 1'b1;
                    q_out_d        = div_if.do_rem ? (a_buf_q - rem_step) : quo_step;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rem_q          <= '0;
            quo_q          <= '0;
            div_q          <= '0;
            a_buf_q        <= '0;
            cnt_q          <= '0;
            q_out_q        <= '0;
            output_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            quo_q          <= quo_d;
            div_q          <= div_d;
            a_buf_q        <= a_buf_d;
            cnt_q          <= cnt_d;
            q_out_q        <= q_out_d;
            output_valid_q <= output_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign div_if.q_out        = q_out_q;
    assign div_if.output_valid = output_valid_q;
    assign div_if.busy         = busy_q;

endmodule
